alu_registered: RTL and testbench
=================================

Name: alu_registered

Overview:
- Registered 32-bit ALU for the datapath execute stage.
- Operands a, b and a 3-bit command produce a result plus carryout, overflow and zero flags.
- Operations: add, subtract, xor, signed set-less-than, and, nand, or, nor.
- Computation is combinational from the inputs; all outputs are registered with 1-cycle latency.

Parameters:
WIDTH, 32, operand/result width in bits (bench and flag rules written for 32).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
command  input  3  operation select
a  input  WIDTH  operand A (two's complement for signed ops)
b  input  WIDTH  operand B
result  output  WIDTH  registered operation result
carryout  output  1  registered carry out of the MSB (add/sub only)
overflow  output  1  registered signed overflow (add/sub only)
zero  output  1  registered flag, 1 when result == 0

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset:
  - On a rising clk edge with reset=1, result=0, carryout=0, overflow=0 and zero=0.
  - Reset has priority over a new computation.
  - Any in-flight result is discarded.
- Latency:
  - Inputs sampled at rising edge N appear on the outputs after edge N.
  - Outputs hold until the next edge.
  - There is no handshake; a new operation is accepted every cycle.
- Command encoding:
  - 0 ADD: result = a + b, modulo 2^32.
  - 1 SUB: result = a + ~b + 1.
  - 2 XOR: result = a ^ b.
  - 3 SLT: result = {31'b0, lt}, where lt = 1 iff a < b as signed 32-bit values.
  - 4 AND: result = a & b.
  - 5 NAND: result = ~(a & b).
  - 6 OR: result = a | b.
  - 7 NOR: result = ~(a | b).
- carryout:
  - ADD: carry out of bit 31.
  - SUB: carry out of bit 31 of a + ~b + 1. This means 1 when a >= b unsigned, including a == b.
  - All other commands: 0.
- overflow:
  - ADD: 1 iff a[31]==b[31] and result[31]!=a[31].
  - SUB: 1 iff a[31]!=b[31] and result[31]!=a[31].
  - All other commands: 0.
- SLT:
  - Must be correct even when a-b overflows: lt = diff[31] XOR sub_overflow.
  - carryout and overflow outputs are 0 for SLT.
- zero: NOR of all 32 bits of the new result, valid for every command including SLT.
- Outputs must never be X after the first reset.
- Unknown or X command handling is not required.

Test Plan:
1. Reset then pipeline:
   - Assert reset for 1 edge -> all outputs 0.
   - Release reset, apply ADD 7ffffffe+00000001 -> next cycle result=7fffffff, co=0, ov=0, z=0.
   - Apply ADD 7ffffffe+00000002 -> result=80000000, co=0, ov=1.
2. ADD negative cases:
   - 08000001+ffffffff -> 08000000, co=1, ov=0.
   - 80000000+ffffffff -> 7fffffff, co=1, ov=1.
   - 40000000+3fffffff -> 7fffffff, co=0, ov=0.
3. SUB cases:
   - 7fffffff-7ffffffe -> 00000001, co=1, ov=0.
   - 7ffffffe-7fffffff -> ffffffff, co=0.
   - 7fffffff-7fffffff -> 00000000, co=1, z=1.
   - ffffffff-7fffffff -> 80000000, co=1, ov=0.
   - fffffffe-7fffffff -> 7fffffff, co=1, ov=1.
4. SLT cases:
   - 7fffffff<7ffffffe -> 0.
   - 7ffffffe<7fffffff -> 1.
   - 1<-1 -> 0 (z=1).
   - -1<1 -> 1.
   - -2<-1 -> 1.
   - 80000000<00000001 -> 1 (overflowing subtract).
   - 00000001<80000000 -> 0.
   - Equal operands -> 0.
   - co=ov=0 in every SLT case.
5. Logic ops with operands aaaaaaaa and 55555555:
   - XOR(aaaaaaaa,55555555) -> ffffffff.
   - AND -> 00000000 (z=1).
   - NAND(aaaaaaaa,aaaaaaaa) -> 55555555.
   - OR -> ffffffff.
   - NOR(55555555,55555555) -> aaaaaaaa.
   - NOR(0,0) -> ffffffff.
   - XOR(ffffffff,ffffffff) -> 0 (z=1).
   - co=ov=0 in every logic case.
6. Mid-stream reset:
   - Issue ADD 7ffffffe+2 and assert reset on the same edge -> outputs all 0.
   - Following cycle, with reset low and SUB 5-5 applied -> result=0, z=1, co=1.

Source files
------------

// File: rtl/alu_registered.sv
// Registered ALU for the execute stage: one shared adder serves ADD/SUB/SLT,
// a bitwise unit serves the logic ops, and every output is registered once.
module alu_registered #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_OR   = 3'd6;
    localparam logic [2:0] CMD_NOR  = 3'd7;

    // SLT reuses the subtractor, so both commands invert b and inject a carry-in
    logic             subtract;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             sum_carry;
    logic             sum_overflow;
    logic             less_than;

    assign subtract = (command == CMD_SUB) || (command == CMD_SLT);
    assign b_eff    = subtract ? ~b : b;

    assign {sum_carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, subtract};

    // Signed overflow: both adder inputs share a sign that the sum does not
    assign sum_overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign less_than    = sum[WIDTH-1] ^ sum_overflow;

    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH-1:0] xor_bits;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic_unit
            assign and_bits[gi] = a[gi] & b[gi];
            assign or_bits[gi]  = a[gi] | b[gi];
            assign xor_bits[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    logic [WIDTH-1:0] result_next;
    logic             carryout_next;
    logic             overflow_next;
    logic             zero_next;

    always_comb begin
        result_next   = '0;
        carryout_next = 1'b0;
        overflow_next = 1'b0;
        case (command)
            CMD_ADD, CMD_SUB: begin
                result_next   = sum;
                carryout_next = sum_carry;
                overflow_next = sum_overflow;
            end
            CMD_XOR:  result_next = xor_bits;
            CMD_SLT:  result_next = {{(WIDTH-1){1'b0}}, less_than};
            CMD_AND:  result_next = and_bits;
            CMD_NAND: result_next = ~and_bits;
            CMD_OR:   result_next = or_bits;
            CMD_NOR:  result_next = ~or_bits;
            default:  result_next = '0;
        endcase
        zero_next = ~|result_next;
    end

    logic [WIDTH-1:0] result_reg;
    logic             carryout_reg;
    logic             overflow_reg;
    logic             zero_reg;

    // zero is forced low in reset even though result is 0 there
    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg   <= '0;
            carryout_reg <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            result_reg   <= result_next;
            carryout_reg <= carryout_next;
            overflow_reg <= overflow_next;
            zero_reg     <= zero_next;
        end
    end

    assign result   = result_reg;
    assign carryout = carryout_reg;
    assign overflow = overflow_reg;
    assign zero     = zero_reg;

endmodule

// File: tb/tb_alu_registered.sv
// Bench for alu_registered: directed tables for each operation class plus
// randomized back-to-back traffic checked against an arithmetic reference model.
module tb_alu_registered;

    logic        clk;
    logic        reset;
    logic [2:0]  command;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        carryout;
    logic        overflow;
    logic        zero;

    int total;
    int bad;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    alu_registered #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .command  (command),
        .a        (a),
        .b        (b),
        .result   (result),
        .carryout (carryout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation, let it cross one rising edge, then sample 1 time unit later
    task automatic apply(input logic rst, input logic [2:0] cmd, input logic [31:0] av, input logic [31:0] bv);
        reset   = rst;
        command = cmd;
        a       = av;
        b       = bv;
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain arithmetic on the operation definitions
    function automatic logic [34:0] model(input logic [2:0] cmd, input logic [31:0] av, input logic [31:0] bv);
        logic [32:0] wide;
        logic [31:0] r;
        logic        co;
        logic        ov;
        r  = '0;
        co = 1'b0;
        ov = 1'b0;
        case (cmd)
            3'd0: begin
                wide = {1'b0, av} + {1'b0, bv};
                r    = wide[31:0];
                co   = wide[32];
                ov   = (av[31] == bv[31]) && (r[31] != av[31]);
            end
            3'd1: begin
                r  = av - bv;
                co = (av >= bv);
                ov = (av[31] != bv[31]) && (r[31] != av[31]);
            end
            3'd2: r = av ^ bv;
            3'd3: r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
            3'd4: r = av & bv;
            3'd5: r = ~(av & bv);
            3'd6: r = av | bv;
            default: r = ~(av | bv);
        endcase
        return {r, co, ov, (r == 32'd0)};
    endfunction

    task automatic test_reset();
        apply(1'b1, 3'd0, 32'h7fff_fffe, 32'h0000_0002);
        total++;
        if ({result, carryout, overflow, zero} !== 35'd0) begin
            bad++;
            $display("FAIL reset: got r=%h co=%b ov=%b z=%b want all 0", result, carryout, overflow, zero);
        end
        $display("reset: r=%h co=%b ov=%b z=%b", result, carryout, overflow, zero);
    endtask

    task automatic test_add();
        vec_t tbl[$];
        tbl = '{
            {3'd0, 32'h7fff_fffe, 32'h0000_0001, 32'h7fff_ffff, 1'b0, 1'b0, 1'b0},
            {3'd0, 32'h7fff_fffe, 32'h0000_0002, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
            {3'd0, 32'h0800_0001, 32'hffff_ffff, 32'h0800_0000, 1'b1, 1'b0, 1'b0},
            {3'd0, 32'h8000_0000, 32'hffff_ffff, 32'h7fff_ffff, 1'b1, 1'b1, 1'b0},
            {3'd0, 32'h4000_0000, 32'h3fff_ffff, 32'h7fff_ffff, 1'b0, 1'b0, 1'b0}
        };
        foreach (tbl[i]) begin
            apply(1'b0, tbl[i].cmd, tbl[i].a, tbl[i].b);
            total++;
            if ({result, carryout, overflow, zero} !== {tbl[i].r, tbl[i].co, tbl[i].ov, tbl[i].z}) begin
                bad++;
                $display("FAIL add[%0d]: got r=%h co=%b ov=%b z=%b want r=%h co=%b ov=%b z=%b", i,
                         result, carryout, overflow, zero, tbl[i].r, tbl[i].co, tbl[i].ov, tbl[i].z);
            end
            $display("add %h+%h -> r=%h co=%b ov=%b z=%b", tbl[i].a, tbl[i].b, result, carryout, overflow, zero);
        end
    endtask

    task automatic test_sub();
        vec_t tbl[$];
        tbl = '{
            {3'd1, 32'h7fff_ffff, 32'h7fff_fffe, 32'h0000_0001, 1'b1, 1'b0, 1'b0},
            {3'd1, 32'h7fff_fffe, 32'h7fff_ffff, 32'hffff_ffff, 1'b0, 1'b0, 1'b0},
            {3'd1, 32'h7fff_ffff, 32'h7fff_ffff, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
            {3'd1, 32'hffff_ffff, 32'h7fff_ffff, 32'h8000_0000, 1'b1, 1'b0, 1'b0},
            {3'd1, 32'hffff_fffe, 32'h7fff_ffff, 32'h7fff_ffff, 1'b1, 1'b1, 1'b0}
        };
        foreach (tbl[i]) begin
            apply(1'b0, tbl[i].cmd, tbl[i].a, tbl[i].b);
            total++;
            if ({result, carryout, overflow, zero} !== {tbl[i].r, tbl[i].co, tbl[i].ov, tbl[i].z}) begin
                bad++;
                $display("FAIL sub[%0d]: got r=%h co=%b ov=%b z=%b want r=%h co=%b ov=%b z=%b", i,
                         result, carryout, overflow, zero, tbl[i].r, tbl[i].co, tbl[i].ov, tbl[i].z);
            end
            $display("sub %h-%h -> r=%h co=%b ov=%b z=%b", tbl[i].a, tbl[i].b, result, carryout, overflow, zero);
        end
    endtask

    task automatic test_slt();
        vec_t tbl[$];
        tbl = '{
            {3'd3, 32'h7fff_ffff, 32'h7fff_fffe, 32'd0, 1'b0, 1'b0, 1'b1},
            {3'd3, 32'h7fff_fffe, 32'h7fff_ffff, 32'd1, 1'b0, 1'b0, 1'b0},
            {3'd3, 32'h0000_0001, 32'hffff_ffff, 32'd0, 1'b0, 1'b0, 1'b1},
            {3'd3, 32'hffff_ffff, 32'h0000_0001, 32'd1, 1'b0, 1'b0, 1'b0},
            {3'd3, 32'hffff_fffe, 32'hffff_ffff, 32'd1, 1'b0, 1'b0, 1'b0},
            {3'd3, 32'h8000_0000, 32'h0000_0001, 32'd1, 1'b0, 1'b0, 1'b0},
            {3'd3, 32'h0000_0001, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b1},
            {3'd3, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b1}
        };
        foreach (tbl[i]) begin
            apply(1'b0, tbl[i].cmd, tbl[i].a, tbl[i].b);
            total++;
            if ({result, carryout, overflow, zero} !== {tbl[i].r, tbl[i].co, tbl[i].ov, tbl[i].z}) begin
                bad++;
                $display("FAIL slt[%0d]: got r=%h co=%b ov=%b z=%b want r=%h co=%b ov=%b z=%b", i,
                         result, carryout, overflow, zero, tbl[i].r, tbl[i].co, tbl[i].ov, tbl[i].z);
            end
            $display("slt %h<%h -> r=%h co=%b ov=%b z=%b", tbl[i].a, tbl[i].b, result, carryout, overflow, zero);
        end
    endtask

    task automatic test_logic();
        vec_t tbl[$];
        tbl = '{
            {3'd2, 32'haaaa_aaaa, 32'h5555_5555, 32'hffff_ffff, 1'b0, 1'b0, 1'b0},
            {3'd4, 32'haaaa_aaaa, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b0, 1'b1},
            {3'd5, 32'haaaa_aaaa, 32'haaaa_aaaa, 32'h5555_5555, 1'b0, 1'b0, 1'b0},
            {3'd6, 32'haaaa_aaaa, 32'h5555_5555, 32'hffff_ffff, 1'b0, 1'b0, 1'b0},
            {3'd7, 32'h5555_5555, 32'h5555_5555, 32'haaaa_aaaa, 1'b0, 1'b0, 1'b0},
            {3'd7, 32'h0000_0000, 32'h0000_0000, 32'hffff_ffff, 1'b0, 1'b0, 1'b0},
            {3'd2, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000, 1'b0, 1'b0, 1'b1}
        };
        foreach (tbl[i]) begin
            apply(1'b0, tbl[i].cmd, tbl[i].a, tbl[i].b);
            total++;
            if ({result, carryout, overflow, zero} !== {tbl[i].r, tbl[i].co, tbl[i].ov, tbl[i].z}) begin
                bad++;
                $display("FAIL logic[%0d]: got r=%h co=%b ov=%b z=%b want r=%h co=%b ov=%b z=%b", i,
                         result, carryout, overflow, zero, tbl[i].r, tbl[i].co, tbl[i].ov, tbl[i].z);
            end
            $display("logic cmd=%0d %h,%h -> r=%h co=%b ov=%b z=%b", tbl[i].cmd, tbl[i].a, tbl[i].b,
                     result, carryout, overflow, zero);
        end
    endtask

    task automatic test_mid_reset();
        apply(1'b0, 3'd2, 32'h1234_5678, 32'h0000_0000);
        apply(1'b1, 3'd0, 32'h7fff_fffe, 32'h0000_0002);
        total++;
        if ({result, carryout, overflow, zero} !== 35'd0) begin
            bad++;
            $display("FAIL mid_reset: got r=%h co=%b ov=%b z=%b want all 0", result, carryout, overflow, zero);
        end
        $display("mid_reset: r=%h co=%b ov=%b z=%b", result, carryout, overflow, zero);
        apply(1'b0, 3'd1, 32'd5, 32'd5);
        total++;
        if ({result, carryout, overflow, zero} !== {32'd0, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL after_reset_sub: got r=%h co=%b ov=%b z=%b want r=0 co=1 ov=0 z=1",
                     result, carryout, overflow, zero);
        end
        $display("after_reset sub 5-5: r=%h co=%b ov=%b z=%b", result, carryout, overflow, zero);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  cmd;
        logic [31:0] av;
        logic [31:0] bv;
        logic [34:0] want;
        for (int n = 0; n < 400; n++) begin
            cmd = 3'($urandom_range(0, 7));
            av  = $urandom;
            bv  = $urandom;
            // Bias toward sign-boundary and equal operands where flags flip
            case ($urandom_range(0, 5))
                0: av = {av[31], 31'h7fff_ffff ^ {31{av[0]}}};
                1: bv = av;
                2: bv = {~av[31], av[30:0]};
                default: ;
            endcase
            want = model(cmd, av, bv);
            apply(1'b0, cmd, av, bv);
            total++;
            if ({result, carryout, overflow, zero} !== want) begin
                bad++;
                $display("FAIL random[%0d]: cmd=%0d a=%h b=%h got r=%h co=%b ov=%b z=%b want r=%h co=%b ov=%b z=%b",
                         n, cmd, av, bv, result, carryout, overflow, zero, want[34:3], want[2], want[1], want[0]);
            end
            $display("random cmd=%0d %h,%h -> r=%h co=%b ov=%b z=%b", cmd, av, bv, result, carryout, overflow, zero);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        command = 3'd0;
        a       = '0;
        b       = '0;
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
